count_arbiter: RTL and testbench

COUNT_ARBITER -- requirements
Module: count_arbiter

---
 rtl/count_pkg.sv | 20 ++
 rtl/count_arbiter_if.sv | 34 +++
 rtl/count_core.sv | 56 +++++
 rtl/count_arbiter.sv | 111 +++++++++++
 tb/tb_count_arbiter.sv | 136 +++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the count arbiter slice: FSM state encoding,
// counter width and modulus, and the LEN-to-steps expansion helper.
package count_pkg;

    localparam int MOD            = 8;
    localparam int LEN_ZERO_MEANS = 8;
    localparam int CNT_W          = 3;
    localparam int REM_W          = 4;   // must hold LEN_ZERO_MEANS

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic logic [REM_W-1:0] steps_of(input logic [CNT_W-1:0] len);
        return (len == '0) ? REM_W'(LEN_ZERO_MEANS) : {1'b0, len};
    endfunction

endpackage

// File: rtl/count_arbiter_if.sv
// Request/grant and counter bus of the count arbiter.
//   REQ[1:0]  : per-requester level request, held until DONE
//   LEN0/LEN1 : step count per requester (0 = 8), sampled at grant
//   STEP      : count-enable strobe
//   GNT[1:0]  : one-hot grant
//   Q[2:0]    : shared mod-8 counter
//   WRAP      : pulse after Q steps 7->0
//   DONE[1:0] : pulse on the requester whose steps completed
//   BUSY      : arbiter not idle
// master = requester side, slave = arbiter side.
interface count_arbiter_if;
    import count_pkg::*;

    logic [1:0]       REQ;
    logic [CNT_W-1:0] LEN0;
    logic [CNT_W-1:0] LEN1;
    logic             STEP;
    logic [1:0]       GNT;
    logic [CNT_W-1:0] Q;
    logic             WRAP;
    logic [1:0]       DONE;
    logic             BUSY;

    modport master (
        output REQ, LEN0, LEN1, STEP,
        input  GNT, Q, WRAP, DONE, BUSY
    );

    modport slave (
        input  REQ, LEN0, LEN1, STEP,
        output GNT, Q, WRAP, DONE, BUSY
    );

endinterface

// File: rtl/count_core.sv
// Shared counter datapath: mod-8 counter, 7->0 wrap pulse and the
// remaining-steps register of the current grant.
//   CLK, RST : clock, synchronous active-low reset
//   load     : clear Q and load remaining from len (0 means 8)
//   len      : step count of the requester being granted
//   step     : advance Q and consume one remaining step
//   q, wrap  : counter value and registered wrap pulse
//   last     : exactly one step remains (next step completes the grant)
module count_core
    import count_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             step,
    output logic [CNT_W-1:0] q,
    output logic             wrap,
    output logic             last
);

    logic [CNT_W-1:0] q_q, q_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        q_d    = q_q;
        rem_d  = rem_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d   = '0;
            rem_d = steps_of(len);
        end else if (step) begin
            q_d    = q_q + 1'b1;          // natural 3-bit wrap is the mod-8 count
            rem_d  = rem_q - 1'b1;
            wrap_d = (q_q == CNT_W'(MOD - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            q_q    <= '0;
            rem_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rem_q  <= rem_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign last = (rem_q == REM_W'(1));

endmodule

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter owning a shared mod-8 counter.
// A granted requester advances the counter with STEP for LEN steps,
// then the arbiter idles GAP cycles before arbitrating again.
//   CLK, RST : clock, synchronous active-low reset
//   bus      : count_arbiter_if.slave (REQ/LEN/STEP in, GNT/Q/WRAP/DONE/BUSY out)
module count_arbiter
    import count_pkg::*;
#(
    parameter int GAP = 1           // idle cycles after a grant ends, 0..3
) (
    input  logic            CLK,
    input  logic            RST,
    count_arbiter_if.slave  bus
);

    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       ptr_q, ptr_d;       // requester favoured on a tie
    logic [1:0] gap_cnt_q, gap_cnt_d;

    logic             sel;
    logic             load;
    logic             step_en;
    logic             last;
    logic             granted_req;
    logic [CNT_W-1:0] len_sel;

    // Only the granted requester's level matters while running.
    assign granted_req = |(bus.REQ & gnt_q);
    assign len_sel     = sel ? bus.LEN1 : bus.LEN0;

    count_core u_core (
        .CLK  (CLK),
        .RST  (RST),
        .load (load),
        .len  (len_sel),
        .step (step_en),
        .q    (bus.Q),
        .wrap (bus.WRAP),
        .last (last)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        ptr_d     = ptr_q;
        gap_cnt_d = gap_cnt_q;
        sel       = 1'b0;
        load      = 1'b0;
        step_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.REQ != 2'b00) begin
                    sel     = (bus.REQ == 2'b11) ? ptr_q : bus.REQ[1];
                    load    = 1'b1;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    ptr_d   = ~sel;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort takes precedence over a coincident STEP.
                if (!granted_req || (bus.STEP && last)) begin
                    if (granted_req) begin
                        step_en = 1'b1;
                        done_d  = gnt_q;
                    end
                    gnt_d = 2'b00;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 2'(GAP_M1);
                    end
                end else if (bus.STEP) begin
                    step_en = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 2'd0) state_d = ST_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 2'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            ptr_q     <= 1'b0;
            gap_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            ptr_q     <= ptr_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.DONE = done_q;
    assign bus.BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter with GAP=1: a vector table for the
// basic grant / alternation / wrap flows and hand sequences for abort,
// gated STEP and mid-run reset.
module tb_count_arbiter;
    import count_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    count_arbiter_if bus ();

    count_arbiter #(.GAP(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic [2:0] len0;
        logic [2:0] len1;
        logic       step;
        logic [1:0] gnt;
        logic [2:0] q;
        logic       wrap;
        logic [1:0] done;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic rst, logic [1:0] req, logic [2:0] len0,
                                logic [2:0] len1, logic step, logic [1:0] gnt,
                                logic [2:0] q, logic wrap, logic [1:0] done,
                                logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.len0 = len0; v.len1 = len1; v.step = step;
        v.gnt = gnt; v.q = q; v.wrap = wrap; v.done = done; v.busy = busy;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, then compare outputs 1 ns after the edge.
    task automatic cyc(string name, logic rst, logic [1:0] req, logic [2:0] len0,
                       logic [2:0] len1, logic step, logic [1:0] gnt,
                       logic [2:0] q, logic wrap, logic [1:0] done, logic busy);
        RST = rst; bus.REQ = req; bus.LEN0 = len0; bus.LEN1 = len1; bus.STEP = step;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.GNT !== gnt || bus.Q !== q || bus.WRAP !== wrap ||
            bus.DONE !== done || bus.BUSY !== busy) begin
            errors++;
            $display("FAIL %s: got gnt=%b q=%0d wrap=%b done=%b busy=%b, want gnt=%b q=%0d wrap=%b done=%b busy=%b",
                     name, bus.GNT, bus.Q, bus.WRAP, bus.DONE, bus.BUSY,
                     gnt, q, wrap, done, busy);
        end
    endtask

    // GNT and DONE must never both bits high.
    always @(negedge CLK) begin
        if (RST) begin
            checks++;
            if (bus.GNT === 2'b11 || bus.DONE === 2'b11) begin
                errors++;
                $display("FAIL onehot: gnt=%b done=%b, want neither 11", bus.GNT, bus.DONE);
            end
        end
    end

    initial begin
        bus.REQ = 2'b00; bus.LEN0 = '0; bus.LEN1 = '0; bus.STEP = 1'b0;

        // Single request, LEN0=3, continuous STEP.
        add(0, 2'b00, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0);
        add(1, 2'b01, 3, 0, 1, 2'b01, 0, 0, 2'b00, 1);
        add(1, 2'b01, 3, 0, 1, 2'b01, 1, 0, 2'b00, 1);
        add(1, 2'b01, 3, 0, 1, 2'b01, 2, 0, 2'b00, 1);
        add(1, 2'b01, 3, 0, 1, 2'b00, 3, 0, 2'b01, 1);
        add(1, 2'b00, 3, 0, 0, 2'b00, 3, 0, 2'b00, 0);
        // Reset ignores REQ=11, then grants alternate 01,10,01.
        add(0, 2'b11, 2, 2, 1, 2'b00, 0, 0, 2'b00, 0);
        add(1, 2'b11, 2, 2, 1, 2'b01, 0, 0, 2'b00, 1);
        add(1, 2'b11, 2, 2, 1, 2'b01, 1, 0, 2'b00, 1);
        add(1, 2'b11, 2, 2, 1, 2'b00, 2, 0, 2'b01, 1);
        add(1, 2'b11, 2, 2, 1, 2'b00, 2, 0, 2'b00, 0);
        add(1, 2'b11, 2, 2, 1, 2'b10, 0, 0, 2'b00, 1);
        add(1, 2'b11, 2, 2, 1, 2'b10, 1, 0, 2'b00, 1);
        add(1, 2'b11, 2, 2, 1, 2'b00, 2, 0, 2'b10, 1);
        add(1, 2'b11, 2, 2, 1, 2'b00, 2, 0, 2'b00, 0);
        add(1, 2'b11, 2, 2, 1, 2'b01, 0, 0, 2'b00, 1);
        add(1, 2'b00, 2, 2, 1, 2'b00, 0, 0, 2'b00, 1);   // drop: abort into GAP
        add(1, 2'b00, 2, 2, 1, 2'b00, 0, 0, 2'b00, 0);
        // Requester 1, LEN1=0 means 8 steps; WRAP coincides with DONE.
        add(1, 2'b10, 0, 0, 1, 2'b10, 0, 0, 2'b00, 1);
        for (int i = 1; i < 8; i++)
            add(1, 2'b10, 0, 0, 1, 2'b10, 3'(i), 0, 2'b00, 1);
        add(1, 2'b10, 0, 0, 1, 2'b00, 0, 1, 2'b10, 1);
        add(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);

        foreach (vecs[i])
            cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].len0,
                vecs[i].len1, vecs[i].step, vecs[i].gnt, vecs[i].q,
                vecs[i].wrap, vecs[i].done, vecs[i].busy);

        // Abort: LEN0=5, REQ0 dropped after two steps.
        cyc("abort_grant", 1, 2'b01, 5, 0, 1, 2'b01, 0, 0, 2'b00, 1);
        cyc("abort_s1",    1, 2'b01, 5, 0, 1, 2'b01, 1, 0, 2'b00, 1);
        cyc("abort_s2",    1, 2'b01, 5, 0, 1, 2'b01, 2, 0, 2'b00, 1);
        cyc("abort_drop",  1, 2'b00, 5, 0, 0, 2'b00, 2, 0, 2'b00, 1);
        cyc("abort_idle",  1, 2'b00, 5, 0, 0, 2'b00, 2, 0, 2'b00, 0);

        // Gated STEP 1,0,1 with LEN0=2.
        cyc("gate_grant",  1, 2'b01, 2, 0, 1, 2'b01, 0, 0, 2'b00, 1);
        cyc("gate_s1",     1, 2'b01, 2, 0, 1, 2'b01, 1, 0, 2'b00, 1);
        cyc("gate_hold",   1, 2'b01, 2, 0, 0, 2'b01, 1, 0, 2'b00, 1);
        cyc("gate_done",   1, 2'b01, 2, 0, 1, 2'b00, 2, 0, 2'b01, 1);
        cyc("gate_idle",   1, 2'b00, 2, 0, 0, 2'b00, 2, 0, 2'b00, 0);

        // Reset at Q=4; pointer then favours requester 1 unless reset clears it.
        cyc("rst_grant",   1, 2'b01, 7, 7, 1, 2'b01, 0, 0, 2'b00, 1);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("rst_s%0d", i), 1, 2'b01, 7, 7, 1, 2'b01, 3'(i), 0, 2'b00, 1);
        cyc("rst_apply",   0, 2'b11, 7, 7, 1, 2'b00, 0, 0, 2'b00, 0);
        cyc("rst_regrant", 1, 2'b11, 7, 7, 1, 2'b01, 0, 0, 2'b00, 1);
        cyc("rst_drop",    1, 2'b00, 7, 7, 0, 2'b00, 0, 0, 2'b00, 1);
        cyc("rst_idle",    1, 2'b00, 7, 7, 0, 2'b00, 0, 0, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
